// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NUM_RD combinational reads, ALU (A) and load (B) writeback,
// optional write-to-read bypass, per-register busy scoreboard and a registered write-conflict flag.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wa_en,
  input  logic [ADDR_W-1:0]        wa_addr,
  input  logic [XLEN-1:0]          wa_data,
  input  logic                     wb_en,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     wr_conflict
);

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic                r_conflict;

  logic w_wa_eff, w_wb_eff, w_iss_eff, w_conflict;

  // Unused codes of a non-power-of-two file and the hardwired zero register are never targets.
  function automatic logic f_valid(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(NUM_REGS)) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign w_wa_eff   = wa_en  && f_valid(wa_addr);
  assign w_wb_eff   = wb_en  && f_valid(wb_addr);
  assign w_iss_eff  = iss_en && f_valid(iss_addr);
  assign w_conflict = w_wa_eff && w_wb_eff && (wa_addr == wb_addr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_conflict;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wb_eff && (wb_addr == ADDR_W'(i))) begin
          r_regs[i] <= wb_data;
        end else if (w_wa_eff && (wa_addr == ADDR_W'(i))) begin
          r_regs[i] <= wa_data;
        end
        // A new issue supersedes the producer that is retiring on this same edge.
        if (w_iss_eff && (iss_addr == ADDR_W'(i))) begin
          r_busy[i] <= 1'b1;
        end else if ((w_wa_eff && (wa_addr == ADDR_W'(i))) ||
                     (w_wb_eff && (wb_addr == ADDR_W'(i)))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign wr_conflict = r_conflict;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [XLEN-1:0]   w_val;
    logic              w_busy;
    logic              w_hit_a, w_hit_b;

    assign w_ra    = rd_addr[k*ADDR_W +: ADDR_W];
    assign w_hit_a = w_wa_eff && (wa_addr == w_ra);
    assign w_hit_b = w_wb_eff && (wb_addr == w_ra);

    always_comb begin
      w_val  = '0;
      w_busy = 1'b0;
      if (f_valid(w_ra)) begin
        w_val  = r_regs[w_ra];
        w_busy = r_busy[w_ra];
      end
      if (BYPASS != 0) begin
        if (w_hit_b) begin
          w_val = wb_data;
        end else if (w_hit_a) begin
          w_val = wa_data;
        end
        if (w_hit_a || w_hit_b) begin
          w_busy = 1'b0;
        end
      end
    end

    // Gate with reset so a write presented during reset cannot bypass onto the read bus.
    assign rd_data[k*XLEN +: XLEN] = reset_n ? w_val : '0;
    assign rd_busy[k]              = reset_n && w_busy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a BYPASS=1 and a BYPASS=0 instance share one stimulus and one model.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic        wa_en = 1'b0, wb_en = 1'b0, iss_en = 1'b0;
  logic [4:0]  wa_addr = '0, wb_addr = '0, iss_addr = '0;
  logic [31:0] wa_data = '0, wb_data = '0;

  logic [63:0] rd_data1, rd_data0;
  logic [1:0]  rd_busy1, rd_busy0;
  logic        conf1, conf0;

  int n_chk  = 0;
  int n_fail = 0;
  bit done   = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .wr_conflict(conf1));

  reg_file_mp #(.BYPASS(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .wr_conflict(conf0));

  // Architectural model: writes applied in order A then B so B wins, issue applied last so it wins.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_conf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 0;
        m_busy[i] = 0;
      end
      m_conf = 0;
    end else begin
      m_conf = wa_en && wb_en && (wa_addr == wb_addr) && (wa_addr != 0);
      if (wa_en && wa_addr != 0) begin
        m_regs[wa_addr] = wa_data;
        m_busy[wa_addr] = 0;
      end
      if (wb_en && wb_addr != 0) begin
        m_regs[wb_addr] = wb_data;
        m_busy[wb_addr] = 0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!reset_n || a == 0) return 32'h0;
    if (byp && wb_en && wb_addr == a) return wb_data;
    if (byp && wa_en && wa_addr == a) return wa_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (!reset_n || a == 0) return 1'b0;
    if (byp && ((wb_en && wb_addr == a) || (wa_en && wa_addr == a))) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (done) break;
      for (int p = 0; p < 2; p++) begin
        chk($sformatf("cmp_b1_rd%0d", p), rd_data1[p*32 +: 32], exp_rd(rd_addr[p*5 +: 5], 1'b1));
        chk($sformatf("cmp_b0_rd%0d", p), rd_data0[p*32 +: 32], exp_rd(rd_addr[p*5 +: 5], 1'b0));
        chk($sformatf("cmp_b1_busy%0d", p), {31'b0, rd_busy1[p]}, {31'b0, exp_busy(rd_addr[p*5 +: 5], 1'b1)});
        chk($sformatf("cmp_b0_busy%0d", p), {31'b0, rd_busy0[p]}, {31'b0, exp_busy(rd_addr[p*5 +: 5], 1'b0)});
      end
      chk("cmp_b1_conf", {31'b0, conf1}, {31'b0, m_conf});
      chk("cmp_b0_conf", {31'b0, conf0}, {31'b0, m_conf});
    end
  end

  task automatic drive(input logic ae, input logic [4:0] aa, input logic [31:0] ad,
                       input logic be, input logic [4:0] ba, input logic [31:0] bd,
                       input logic ie, input logic [4:0] ia);
    @(posedge clk);
    #1;
    wa_en = ae; wa_addr = aa; wa_data = ad;
    wb_en = be; wb_addr = ba; wb_data = bd;
    iss_en = ie; iss_addr = ia;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rd_addr = {5'd7, 5'd5};
    #2;
    chk("rst_rd0", rd_data1[31:0], 32'h0);
    chk("rst_busy", {30'b0, rd_busy1}, 32'h0);
    chk("rst_conf", {31'b0, conf1}, 32'h0);
    #10 reset_n = 1'b1;

    // Port A write to r5: bypass shows it immediately, no-bypass one cycle later.
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("wa_r5_byp", rd_data1[31:0], 32'hDEADBEEF);
    chk("wa_r5_nobyp", rd_data0[31:0], 32'h0);
    idle();
    chk("r5_next_b1", rd_data1[31:0], 32'hDEADBEEF);
    chk("r5_next_b0", rd_data0[31:0], 32'hDEADBEEF);

    // Both ports to r7: B wins, one-cycle conflict pulse.
    drive(1, 7, 32'h11111111, 1, 7, 32'h22222222, 0, 0);
    chk("r7_byp_b", rd_data1[63:32], 32'h22222222);
    chk("conf_before", {31'b0, conf1}, 32'h0);
    idle();
    chk("conf_pulse", {31'b0, conf1}, 32'h1);
    chk("r7_stored", rd_data0[63:32], 32'h22222222);
    idle();
    chk("conf_gone", {31'b0, conf1}, 32'h0);

    // Zero register ignores writes, issues and conflicts.
    rd_addr = {5'd7, 5'd0};
    drive(1, 0, 32'h12345678, 1, 0, 32'h9, 1, 0);
    chk("r0_byp", rd_data1[31:0], 32'h0);
    chk("r0_busy", {31'b0, rd_busy1[0]}, 32'h0);
    idle();
    chk("r0_after", rd_data0[31:0], 32'h0);
    chk("r0_noconf", {31'b0, conf1}, 32'h0);

    // Scoreboard: issue r3, then same-edge write+issue keeps busy, plain write clears it.
    rd_addr = {5'd7, 5'd3};
    drive(0, 0, 0, 0, 0, 0, 1, 3);
    chk("iss_same_cycle", {31'b0, rd_busy1[0]}, 32'h0);
    idle();
    chk("iss_busy", {31'b0, rd_busy1[0]}, 32'h1);
    drive(0, 0, 0, 1, 3, 32'hA5, 1, 3);
    chk("r3_byp", rd_data1[31:0], 32'hA5);
    chk("r3_busy_masked", {31'b0, rd_busy1[0]}, 32'h0);
    chk("r3_busy_nobyp", {31'b0, rd_busy0[0]}, 32'h1);
    idle();
    chk("r3_val", rd_data0[31:0], 32'hA5);
    chk("r3_still_busy", {31'b0, rd_busy1[0]}, 32'h1);
    drive(1, 3, 32'h77, 0, 0, 0, 0, 0);
    idle();
    chk("r3_cleared", {31'b0, rd_busy1[0]}, 32'h0);
    chk("r3_new", rd_data1[31:0], 32'h77);

    // No-bypass build shows the old value during the write cycle.
    rd_addr = {5'd7, 5'd9};
    drive(1, 9, 32'h55, 0, 0, 0, 0, 0);
    chk("r9_nobyp_same", rd_data0[31:0], 32'h0);
    chk("r9_byp_same", rd_data1[31:0], 32'h55);
    idle();
    chk("r9_nobyp_next", rd_data0[31:0], 32'h55);

    // Mid-cycle asynchronous reset with r5 written and r3 busy.
    rd_addr = {5'd3, 5'd5};
    drive(0, 0, 0, 0, 0, 0, 1, 3);
    idle();
    chk("pre_rst_r5", rd_data1[31:0], 32'hDEADBEEF);
    chk("pre_rst_busy3", {31'b0, rd_busy1[1]}, 32'h1);
    #1;
    reset_n = 1'b0;
    rd_addr = {5'd11, 5'd5};
    wa_en = 1; wa_addr = 11; wa_data = 32'hCAFE;
    #1;
    chk("rst_async_r5", rd_data1[31:0], 32'h0);
    chk("rst_async_r11", rd_data1[63:32], 32'h0);
    rd_addr = {5'd11, 5'd3};
    #1;
    chk("rst_async_busy3", {31'b0, rd_busy0[0]}, 32'h0);
    @(posedge clk);
    #3;
    wa_en = 0;
    reset_n = 1'b1;
    idle();
    chk("rst_r11_dropped", rd_data0[63:32], 32'h0);
    chk("rst_busy3_gone", {31'b0, rd_busy1[0]}, 32'h0);
    idle();

    done = 1;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
